// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control unit: opcodes, funct/ALU codes,
// datapath mux selects and the 4-bit FSM state encoding.
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   // ALU operations share the R-type funct encoding
   localparam logic [5:0] ALU_ADD = 6'b100000;
   localparam logic [5:0] ALU_SUB = 6'b100010;
   localparam logic [5:0] ALU_AND = 6'b100100;
   localparam logic [5:0] ALU_OR  = 6'b100101;
   localparam logic [5:0] ALU_XOR = 6'b100110;
   localparam logic [5:0] ALU_NOR = 6'b100111;
   localparam logic [5:0] ALU_SLT = 6'b101010;
   localparam logic [5:0] ALU_SLL = 6'b000000;
   localparam logic [5:0] ALU_SRL = 6'b000010;
   localparam logic [5:0] ALU_SRA = 6'b000011;
   localparam logic [5:0] ALU_NOP = 6'b000000;

   localparam logic [1:0] SRCB_B      = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef enum logic [3:0] {
      ST_FETCH  = 4'd0,
      ST_DECODE = 4'd1,
      ST_EXEC_R = 4'd2,
      ST_WB_R   = 4'd3,
      ST_EXEC_I = 4'd4,
      ST_WB_I   = 4'd5,
      ST_ADDR   = 4'd6,
      ST_MEM_RD = 4'd7,
      ST_WB_L   = 4'd8,
      ST_MEM_WR = 4'd9,
      ST_BRANCH = 4'd10,
      ST_JUMP   = 4'd11
   } state_t;

   function automatic logic is_shift(input logic [5:0] fn);
      return (fn == ALU_SLL) || (fn == ALU_SRL) || (fn == ALU_SRA);
   endfunction

endpackage

// File: rtl/mips_mc_ctrl_alu_op_dec.sv
// ALU operation decoder: maps (state, opcode, funct) to alu_control, shift_op,
// ext_zero and whether the R-type funct is one the datapath supports.
module alu_op_dec
   import mips_pkg::*;
(
   input  state_t      state,
   input  logic [5:0]  opcode,
   input  logic [5:0]  funct,
   output logic [5:0]  alu_control,
   output logic        shift_op,
   output logic        ext_zero,
   output logic        funct_valid
);

   // Supported R-type funct set
   always_comb begin
      case (funct)
         ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
         ALU_NOR, ALU_SLT, ALU_SLL, ALU_SRL, ALU_SRA: funct_valid = 1'b1;
         default:                                    funct_valid = 1'b0;
      endcase
   end

   // Per-state ALU operation selection
   always_comb begin
      alu_control = ALU_NOP;
      shift_op    = 1'b0;
      ext_zero    = 1'b0;
      case (state)
         ST_FETCH, ST_DECODE, ST_ADDR: alu_control = ALU_ADD;
         ST_BRANCH:                    alu_control = ALU_SUB;
         ST_EXEC_R: begin
            alu_control = funct;
            shift_op    = is_shift(funct);
         end
         ST_EXEC_I: begin
            case (opcode)
               OP_SLTI: alu_control = ALU_SLT;
               OP_ANDI: alu_control = ALU_AND;
               OP_ORI:  alu_control = ALU_OR;
               OP_XORI: alu_control = ALU_XOR;
               default: alu_control = ALU_ADD;
            endcase
            ext_zero = (opcode == OP_ANDI) || (opcode == OP_ORI) || (opcode == OP_XORI);
         end
         default: alu_control = ALU_NOP;
      endcase
   end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS control FSM with a shared-memory req/ready handshake and a
// bounded wait-cycle timeout that aborts the instruction and reports bus_err.
module mips_mc_ctrl
   import mips_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_we,
   output logic       iord,
   output logic       ir_write,
   output logic       pc_write,
   output logic [1:0] pc_src,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic       ext_zero,
   output logic       shift_op,
   output logic [5:0] alu_control,
   output logic       reg_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       illegal,
   output logic       bus_err
);

   localparam int              WCW       = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [WCW-1:0]  WAIT_LAST = WCW'((MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0);
   localparam logic            TO_EN     = (MEM_TIMEOUT != 0);

   state_t         state_r;
   state_t         decode_next_s;
   logic [WCW-1:0] wait_cnt_r;
   logic           illegal_op_s;
   logic           funct_valid_s;
   logic           timeout_s;
   logic           branch_take_s;
   logic           mem_req_s, mem_we_s, iord_s, alu_src_a_s;
   logic           reg_write_s, reg_dst_s, mem_to_reg_s;
   logic [1:0]     pc_src_s, alu_src_b_s;
   logic [5:0]     alu_control_s;
   logic           shift_op_s, ext_zero_s;

   alu_op_dec u_alu_op_dec (
      .state       (state_r),
      .opcode      (opcode),
      .funct       (funct),
      .alu_control (alu_control_s),
      .shift_op    (shift_op_s),
      .ext_zero    (ext_zero_s),
      .funct_valid (funct_valid_s)
   );

   assign timeout_s     = TO_EN && mem_req_s && !mem_ready && (wait_cnt_r == WAIT_LAST);
   assign branch_take_s = ((opcode == OP_BEQ) && zero) || ((opcode == OP_BNE) && !zero);

   // Instruction class dispatch out of DECODE
   always_comb begin
      decode_next_s = ST_FETCH;
      illegal_op_s  = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            if (funct_valid_s) begin
               decode_next_s = ST_EXEC_R;
            end else begin
               illegal_op_s  = 1'b1;
            end
         end
         OP_LW, OP_SW:   decode_next_s = ST_ADDR;
         OP_BEQ, OP_BNE: decode_next_s = ST_BRANCH;
         OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: decode_next_s = ST_EXEC_I;
         OP_J:           decode_next_s = ST_JUMP;
         default:        illegal_op_s  = 1'b1;
      endcase
   end

   // Moore datapath controls decoded from the state register
   always_comb begin
      mem_req_s    = 1'b0;
      mem_we_s     = 1'b0;
      iord_s       = 1'b0;
      pc_src_s     = PCSRC_ALU;
      alu_src_a_s  = 1'b0;
      alu_src_b_s  = SRCB_B;
      reg_write_s  = 1'b0;
      reg_dst_s    = 1'b0;
      mem_to_reg_s = 1'b0;
      case (state_r)
         ST_FETCH: begin
            mem_req_s   = 1'b1;
            alu_src_b_s = SRCB_FOUR;
         end
         ST_DECODE: alu_src_b_s = SRCB_IMM_SH;
         ST_EXEC_R: alu_src_a_s = 1'b1;
         ST_WB_R: begin
            reg_write_s = 1'b1;
            reg_dst_s   = 1'b1;
         end
         ST_EXEC_I, ST_ADDR: begin
            alu_src_a_s = 1'b1;
            alu_src_b_s = SRCB_IMM;
         end
         ST_WB_I: reg_write_s = 1'b1;
         ST_MEM_RD: begin
            mem_req_s = 1'b1;
            iord_s    = 1'b1;
         end
         ST_WB_L: begin
            reg_write_s  = 1'b1;
            mem_to_reg_s = 1'b1;
         end
         ST_MEM_WR: begin
            mem_req_s = 1'b1;
            mem_we_s  = 1'b1;
            iord_s    = 1'b1;
         end
         ST_BRANCH: begin
            alu_src_a_s = 1'b1;
            pc_src_s    = PCSRC_ALUOUT;
         end
         ST_JUMP: pc_src_s = PCSRC_JUMP;
         default: mem_req_s = 1'b0;
      endcase
   end

   // State sequencing and memory wait counter
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= ST_FETCH;
         wait_cnt_r <= '0;
      end else begin
         if (mem_req_s && !mem_ready && !timeout_s) begin
            wait_cnt_r <= wait_cnt_r + WCW'(1);
         end else begin
            wait_cnt_r <= '0;
         end
         case (state_r)
            ST_FETCH:  state_r <= mem_ready ? ST_DECODE : ST_FETCH;
            ST_DECODE: state_r <= decode_next_s;
            ST_EXEC_R: state_r <= ST_WB_R;
            ST_EXEC_I: state_r <= ST_WB_I;
            ST_ADDR:   state_r <= (opcode == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
            ST_MEM_RD: begin
               if (mem_ready) begin
                  state_r <= ST_WB_L;
               end else if (timeout_s) begin
                  state_r <= ST_FETCH;
               end
            end
            ST_MEM_WR: begin
               if (mem_ready || timeout_s) begin
                  state_r <= ST_FETCH;
               end
            end
            default:   state_r <= ST_FETCH;
         endcase
      end
   end

   // Reset forces every output low; strobes carry their Mealy qualifiers
   assign mem_req     = !rst && mem_req_s;
   assign mem_we      = !rst && mem_we_s;
   assign iord        = !rst && iord_s;
   assign pc_src      = rst ? 2'b00 : pc_src_s;
   assign alu_src_a   = !rst && alu_src_a_s;
   assign alu_src_b   = rst ? 2'b00 : alu_src_b_s;
   assign ext_zero    = !rst && ext_zero_s;
   assign shift_op    = !rst && shift_op_s;
   assign alu_control = rst ? 6'b000000 : alu_control_s;
   assign reg_write   = !rst && reg_write_s;
   assign reg_dst     = !rst && reg_dst_s;
   assign mem_to_reg  = !rst && mem_to_reg_s;
   assign ir_write    = !rst && (state_r == ST_FETCH) && mem_ready;
   assign pc_write    = !rst && (((state_r == ST_FETCH) && mem_ready) ||
                                 (state_r == ST_JUMP) ||
                                 ((state_r == ST_BRANCH) && branch_take_s));
   assign illegal     = !rst && (state_r == ST_DECODE) && illegal_op_s;
   assign bus_err     = !rst && timeout_s;

endmodule

// File: doc/mips_mc_ctrl.md
Name: mips_mc_ctrl

Overview:
- Multicycle MIPS control unit. Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives the datapath muxes, the write strobes and the 6-bit funct-encoded alu_control consumed by alu.
- Handshakes with a shared instruction/data memory through a req/ready pair, with a wait-cycle timeout.

Parameters:
- MEM_TIMEOUT, 16: max cycles mem_req may wait for mem_ready; 0 disables the timeout.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- opcode  in  6  IR[31:26].
- funct  in  6  IR[5:0].
- zero  in  1  alu zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access request.
- mem_we  out  1  write enable, qualifies mem_req.
- iord  out  1  address select: 0 = PC, 1 = ALUOut.
- ir_write  out  1  load IR.
- pc_write  out  1  load PC.
- pc_src  out  2  next PC: 00 ALU result, 01 ALUOut, 10 jump target.
- alu_src_a  out  1  0 = PC, 1 = A register.
- alu_src_b  out  2  00 = B, 01 = const 4, 10 = ext imm, 11 = ext imm<<2.
- ext_zero  out  1  1 = zero-extend imm, 0 = sign-extend imm.
- shift_op  out  1  datapath routes rt to ALU a and shamt to ALU b.
- alu_control  out  6  ALU op in funct encoding.
- reg_write  out  1  register file write.
- reg_dst  out  1  1 = rd, 0 = rt.
- mem_to_reg  out  1  1 = MDR, 0 = ALUOut.
- illegal  out  1  one-cycle pulse on an unsupported opcode or funct.
- bus_err  out  1  one-cycle pulse on memory timeout.

Behaviour:
- Output timing: outputs are combinational from the state register (Moore). Exceptions are ir_write, pc_write, illegal and bus_err, which are also gated by mem_ready, zero or the decode result (Mealy).
- rst: while rst=1 every output is 0. At the next edge state=FETCH and wait_cnt=0.
- rst mid-instruction: the partial instruction is abandoned and no write strobe fires after that edge.
- FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_control=ADD(100000), pc_src=00.
  - On mem_ready: ir_write=1, pc_write=1, go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: ADD with src_a=0 and src_b=11 computes the branch target into ALUOut. Next state by opcode:
  - R-type(000000) goes to EXEC_R; an unsupported funct pulses illegal and goes to FETCH.
  - lw(100011) and sw(101011) go to ADDR.
  - beq(000100) and bne(000101) go to BRANCH.
  - addi(001000), slti(001010), andi(001100), ori(001101), xori(001110) go to EXEC_I.
  - j(000010) goes to JUMP.
  - Any other opcode pulses illegal and goes to FETCH.
- EXEC_R: src_a=1, src_b=00, alu_control=funct. shift_op=1 for funct 000000, 000010 or 000011. Goes to WB_R.
  - Supported funct: 100000, 100010, 100100, 100101, 100110, 100111, 101010, 000000, 000010, 000011.
- WB_R: reg_write=1, reg_dst=1, mem_to_reg=0. Goes to FETCH.
- EXEC_I: src_a=1, src_b=10. Goes to WB_I.
  - addi uses ADD; slti uses SLT(101010).
  - andi, ori, xori use AND(100100), OR(100101), XOR(100110) with ext_zero=1.
- WB_I: reg_write=1, reg_dst=0, mem_to_reg=0. Goes to FETCH.
- ADDR: ADD with src_a=1, src_b=10. lw goes to MEM_RD, sw goes to MEM_WR.
- MEM_RD: mem_req=1, iord=1. Holds until mem_ready, then goes to WB_L.
- WB_L: reg_write=1, reg_dst=0, mem_to_reg=1. Goes to FETCH.
- MEM_WR: mem_req=1, mem_we=1, iord=1. On mem_ready goes to FETCH.
- BRANCH: SUB(100010) with src_a=1, src_b=00, pc_src=01. Goes to FETCH.
  - pc_write = (beq & zero) | (bne & ~zero).
- JUMP: pc_src=10, pc_write=1. Goes to FETCH.
- Cycle counts with zero-wait memory:
  - R-type 4, I-ALU 4, lw 5, sw 4, beq/bne 3, j 3.
  - Each memory wait cycle adds 1.
- Timeout:
  - wait_cnt increments each cycle mem_req=1 and mem_ready=0, and clears on mem_ready or on a state change.
  - When wait_cnt reaches MEM_TIMEOUT-1 with mem_ready still low, bus_err pulses, no write strobe fires, and the FSM goes to FETCH.
  - mem_ready arriving in the same cycle as that terminal count wins: normal completion, no bus_err.
- Encodings: mem_we is never 1 without mem_req. reg_write and pc_write are never both 1 in the same cycle.

Decomposition:
- mips_pkg holds:
  - opcode and funct localparams, ALU op codes matching alu;
  - the state encoding (4-bit);
  - the alu_src_b and pc_src encodings.
- Sub-module alu_op_dec: combinational mapping from (state, opcode, funct) to alu_control, shift_op, ext_zero and a funct_valid flag.

Test Plan:
- add rd (op 000000, funct 100000), mem_ready=1 -> 4 cycles; FETCH alu_control=100000 with ir_write=pc_write=1; EXEC alu_control=100000; WB reg_write=1, reg_dst=1.
- beq with zero=1, then bne with zero=1 -> beq: cycle 3 pc_write=1, pc_src=01, alu_control=100010. bne: pc_write=0.
- lw with mem_ready low for 3 cycles in MEM_RD -> mem_req and iord held 3 extra cycles; lw takes 8 cycles; WB_L mem_to_reg=1.
- ori (001101) -> EXEC_I alu_control=100101 with ext_zero=1; sra funct 000011 -> alu_control=000011 with shift_op=1.
- opcode 111111 -> illegal pulses once in DECODE, next state FETCH, no reg_write. mem_ready held 0 in FETCH with MEM_TIMEOUT=16 -> bus_err on the 16th wait cycle, no ir_write.
- rst asserted during MEM_WR -> mem_req and mem_we=0 while rst is high; FETCH after release.
